// File: rtl/axi_mux_sched.sv
// axi_mux_sched: AW/AR arbitration with in-order W/B/R steering for a shared AXI4 port.
// Define AXI_MUX_SCHED_FIXED_PRIO_EN for fixed-priority arbitration (slot 0 highest) instead of round-robin.
module axi_mux_sched_arb #(
  parameter int slot_num_p = 2,
  parameter int lg_slot_lp = $clog2(slot_num_p)
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic [slot_num_p-1:0] v_i,
  input  logic                  block_i,
  input  logic                  m_ready_i,
  output logic                  m_valid_o,
  output logic [slot_num_p-1:0] ready_o,
  output logic [lg_slot_lp-1:0] sel_o,
  output logic                  hs_o
);
  typedef enum logic {IDLE, HOLD} state_e;
  state_e state_q, state_d;
  logic [lg_slot_lp-1:0] hold_q, rr_q, pick;
  logic [lg_slot_lp:0] idx;
`ifdef AXI_MUX_SCHED_FIXED_PRIO_EN
  assign rr_q = '0;
`else
  logic [lg_slot_lp-1:0] rr_d;
  assign rr_d = !hs_o ? rr_q : sel_o == lg_slot_lp'(slot_num_p - 1) ? '0 : sel_o + lg_slot_lp'(1);
  always_ff @(posedge clk_i) rr_q <= reset_i ? '0 : rr_d;
`endif
  // Scan from the farthest slot back so the requester closest to rr_q wins.
  always_comb begin
    pick = rr_q;
    idx = '0;
    for (int i = slot_num_p - 1; i >= 0; i--) begin
      idx = {1'b0, rr_q} + (lg_slot_lp+1)'(i);
      if (idx >= (lg_slot_lp+1)'(slot_num_p)) idx = idx - (lg_slot_lp+1)'(slot_num_p);
      if (v_i[idx[lg_slot_lp-1:0]]) pick = idx[lg_slot_lp-1:0];
    end
  end
  always_comb begin
    sel_o = state_q == HOLD ? hold_q : pick;
    m_valid_o = state_q == HOLD || (|v_i && !block_i);
    hs_o = m_valid_o && m_ready_i;
    ready_o = '0;
    ready_o[sel_o] = hs_o;
    state_d = m_valid_o && !m_ready_i ? HOLD : IDLE;
  end
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      hold_q <= '0;
    end else begin
      state_q <= state_d;
      hold_q <= sel_o;
    end
  end
endmodule

module axi_mux_sched_fifo #(
  parameter int depth_p = 8,
  parameter int width_p = 1
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               push_i,
  input  logic [width_p-1:0] data_i,
  input  logic               pop_i,
  output logic [width_p-1:0] data_o,
  output logic               empty_o,
  output logic               full_o
);
  localparam int lg_lp = $clog2(depth_p);
  logic [width_p-1:0] mem_q [depth_p];
  logic [lg_lp-1:0] wp_q, rp_q;
  logic [lg_lp:0] cnt_q;
  assign empty_o = cnt_q == '0;
  assign full_o = cnt_q == (lg_lp+1)'(depth_p);
  assign data_o = empty_o ? '0 : mem_q[rp_q];
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wp_q <= '0;
      rp_q <= '0;
      cnt_q <= '0;
    end else begin
      if (push_i) wp_q <= wp_q + lg_lp'(1);
      if (pop_i) rp_q <= rp_q + lg_lp'(1);
      cnt_q <= cnt_q + (lg_lp+1)'(push_i) - (lg_lp+1)'(pop_i);
    end
  end
  always_ff @(posedge clk_i) if (push_i) mem_q[wp_q] <= data_i;
endmodule

module axi_mux_sched #(
  parameter int slot_num_p = 2,
  parameter int max_out_p = 8,
  localparam int lg_slot_lp = $clog2(slot_num_p)
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic [slot_num_p-1:0] aw_v_i,
  output logic [slot_num_p-1:0] aw_ready_o,
  output logic                  m_awvalid_o,
  input  logic                  m_awready_i,
  output logic [lg_slot_lp-1:0] aw_sel_o,
  input  logic [slot_num_p-1:0] w_v_i,
  input  logic [slot_num_p-1:0] w_last_i,
  output logic [slot_num_p-1:0] w_ready_o,
  output logic                  m_wvalid_o,
  input  logic                  m_wready_i,
  output logic [lg_slot_lp-1:0] w_sel_o,
  input  logic                  m_bvalid_i,
  output logic                  m_bready_o,
  output logic [slot_num_p-1:0] b_v_o,
  input  logic [slot_num_p-1:0] b_ready_i,
  input  logic [slot_num_p-1:0] ar_v_i,
  output logic [slot_num_p-1:0] ar_ready_o,
  output logic                  m_arvalid_o,
  input  logic                  m_arready_i,
  output logic [lg_slot_lp-1:0] ar_sel_o,
  input  logic                  m_rvalid_i,
  input  logic                  m_rlast_i,
  output logic                  m_rready_o,
  output logic [slot_num_p-1:0] r_v_o,
  input  logic [slot_num_p-1:0] r_ready_i
);
  logic aw_hs, ar_hs, w_pop, b_pop, r_pop;
  logic wq_empty, wq_full, bq_empty, bq_full, rq_empty, rq_full;
  logic [lg_slot_lp-1:0] wq_head, bq_head, rq_head;

  axi_mux_sched_arb #(.slot_num_p(slot_num_p)) aw_arb (
    .clk_i(clk_i), .reset_i(reset_i), .v_i(aw_v_i), .block_i(wq_full || bq_full),
    .m_ready_i(m_awready_i), .m_valid_o(m_awvalid_o), .ready_o(aw_ready_o), .sel_o(aw_sel_o), .hs_o(aw_hs)
  );
  axi_mux_sched_arb #(.slot_num_p(slot_num_p)) ar_arb (
    .clk_i(clk_i), .reset_i(reset_i), .v_i(ar_v_i), .block_i(rq_full),
    .m_ready_i(m_arready_i), .m_valid_o(m_arvalid_o), .ready_o(ar_ready_o), .sel_o(ar_sel_o), .hs_o(ar_hs)
  );
  axi_mux_sched_fifo #(.depth_p(max_out_p), .width_p(lg_slot_lp)) wq (
    .clk_i(clk_i), .reset_i(reset_i), .push_i(aw_hs), .data_i(aw_sel_o), .pop_i(w_pop),
    .data_o(wq_head), .empty_o(wq_empty), .full_o(wq_full)
  );
  axi_mux_sched_fifo #(.depth_p(max_out_p), .width_p(lg_slot_lp)) bq (
    .clk_i(clk_i), .reset_i(reset_i), .push_i(aw_hs), .data_i(aw_sel_o), .pop_i(b_pop),
    .data_o(bq_head), .empty_o(bq_empty), .full_o(bq_full)
  );
  axi_mux_sched_fifo #(.depth_p(max_out_p), .width_p(lg_slot_lp)) rq (
    .clk_i(clk_i), .reset_i(reset_i), .push_i(ar_hs), .data_i(ar_sel_o), .pop_i(r_pop),
    .data_o(rq_head), .empty_o(rq_empty), .full_o(rq_full)
  );

  // Downstream answers in issue order, so each queue head owns the current beat.
  always_comb begin
    w_sel_o = wq_head;
    m_wvalid_o = !wq_empty && w_v_i[wq_head];
    w_ready_o = '0;
    w_ready_o[wq_head] = !wq_empty && m_wready_i;
    w_pop = m_wvalid_o && m_wready_i && w_last_i[wq_head];
    b_v_o = '0;
    b_v_o[bq_head] = !bq_empty && m_bvalid_i;
    m_bready_o = !bq_empty && b_ready_i[bq_head];
    b_pop = m_bvalid_i && m_bready_o;
    r_v_o = '0;
    r_v_o[rq_head] = !rq_empty && m_rvalid_i;
    m_rready_o = !rq_empty && r_ready_i[rq_head];
    r_pop = m_rvalid_i && m_rready_o && m_rlast_i;
  end

  assert property (@(posedge clk_i) disable iff (reset_i) !(m_bvalid_i && bq_empty));
  assert property (@(posedge clk_i) disable iff (reset_i) !(m_rvalid_i && rq_empty));
endmodule

// File: tb/tb_axi_mux_sched.sv
// tb_axi_mux_sched: queue-level reference model compared every cycle plus directed literal checks.
module tb_axi_mux_sched;
  localparam int N = 2;
  localparam int MAX = 8;
  localparam int LG = $clog2(N);

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [N-1:0] aw_v, aw_ready, w_v, w_last, w_ready, b_v, b_ready, ar_v, ar_ready, r_v, r_ready;
  logic m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;
  logic m_arvalid, m_arready, m_rvalid, m_rlast, m_rready;
  logic [LG-1:0] aw_sel, w_sel, ar_sel;

  axi_mux_sched #(.slot_num_p(N), .max_out_p(MAX)) dut (
    .clk_i(clk), .reset_i(rst),
    .aw_v_i(aw_v), .aw_ready_o(aw_ready), .m_awvalid_o(m_awvalid), .m_awready_i(m_awready), .aw_sel_o(aw_sel),
    .w_v_i(w_v), .w_last_i(w_last), .w_ready_o(w_ready), .m_wvalid_o(m_wvalid), .m_wready_i(m_wready), .w_sel_o(w_sel),
    .m_bvalid_i(m_bvalid), .m_bready_o(m_bready), .b_v_o(b_v), .b_ready_i(b_ready),
    .ar_v_i(ar_v), .ar_ready_o(ar_ready), .m_arvalid_o(m_arvalid), .m_arready_i(m_arready), .ar_sel_o(ar_sel),
    .m_rvalid_i(m_rvalid), .m_rlast_i(m_rlast), .m_rready_o(m_rready), .r_v_o(r_v), .r_ready_i(r_ready)
  );

  int n_chk = 0;
  int n_fail = 0;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: ordered slot lists plus arbitration pointer and pending grant.
  int wq_m[$], bq_m[$], rq_m[$], aw_log[$];
  int aw_rr = 0, ar_rr = 0, aw_pend = -1, ar_pend = -1;
  int e_aws, e_ars, h;
  logic e_awv, e_arv, e_aw_hs, e_ar_hs;

  function automatic int pick(input logic [N-1:0] v, input int rr);
    for (int i = 0; i < N; i++) if (v[(rr + i) % N]) return (rr + i) % N;
    return -1;
  endfunction

  always @(negedge clk) begin
    if (aw_pend >= 0) begin
      e_awv = 1'b1;
      e_aws = aw_pend;
    end else begin
      e_aws = pick(aw_v, aw_rr);
      e_awv = e_aws >= 0 && wq_m.size() < MAX && bq_m.size() < MAX;
    end
    e_aw_hs = e_awv && m_awready;
    if (ar_pend >= 0) begin
      e_arv = 1'b1;
      e_ars = ar_pend;
    end else begin
      e_ars = pick(ar_v, ar_rr);
      e_arv = e_ars >= 0 && rq_m.size() < MAX;
    end
    e_ar_hs = e_arv && m_arready;
    if (!rst) begin
      check("m_awvalid", m_awvalid, e_awv);
      if (e_awv) check("aw_sel", aw_sel, e_aws);
      check("aw_ready", aw_ready, e_aw_hs ? 1 << e_aws : 0);
      check("m_arvalid", m_arvalid, e_arv);
      if (e_arv) check("ar_sel", ar_sel, e_ars);
      check("ar_ready", ar_ready, e_ar_hs ? 1 << e_ars : 0);
      if (wq_m.size() > 0) begin
        h = wq_m[0];
        check("w_sel", w_sel, h);
        check("m_wvalid", m_wvalid, w_v[h]);
        check("w_ready", w_ready, m_wready ? 1 << h : 0);
      end else begin
        check("m_wvalid_idle", m_wvalid, 0);
        check("w_ready_idle", w_ready, 0);
      end
      if (bq_m.size() > 0) begin
        h = bq_m[0];
        check("b_v", b_v, m_bvalid ? 1 << h : 0);
        check("m_bready", m_bready, b_ready[h]);
      end else begin
        check("b_v_idle", b_v, 0);
        check("m_bready_idle", m_bready, 0);
      end
      if (rq_m.size() > 0) begin
        h = rq_m[0];
        check("r_v", r_v, m_rvalid ? 1 << h : 0);
        check("m_rready", m_rready, r_ready[h]);
      end else begin
        check("r_v_idle", r_v, 0);
        check("m_rready_idle", m_rready, 0);
      end
    end
  end

  always @(posedge clk) begin
    if (rst) begin
      wq_m.delete(); bq_m.delete(); rq_m.delete();
      aw_rr = 0; ar_rr = 0; aw_pend = -1; ar_pend = -1;
    end else begin
      if (wq_m.size() > 0 && w_v[wq_m[0]] && m_wready && w_last[wq_m[0]]) void'(wq_m.pop_front());
      if (bq_m.size() > 0 && m_bvalid && b_ready[bq_m[0]]) void'(bq_m.pop_front());
      if (rq_m.size() > 0 && m_rvalid && r_ready[rq_m[0]] && m_rlast) void'(rq_m.pop_front());
      if (e_aw_hs) begin
        wq_m.push_back(e_aws); bq_m.push_back(e_aws); aw_log.push_back(e_aws);
`ifndef AXI_MUX_SCHED_FIXED_PRIO_EN
        aw_rr = (e_aws + 1) % N;
`endif
        aw_pend = -1;
      end else if (e_awv) aw_pend = e_aws;
      if (e_ar_hs) begin
        rq_m.push_back(e_ars);
`ifndef AXI_MUX_SCHED_FIXED_PRIO_EN
        ar_rr = (e_ars + 1) % N;
`endif
        ar_pend = -1;
      end else if (e_arv) ar_pend = e_ars;
    end
  end

`ifdef AXI_MUX_SCHED_FIXED_PRIO_EN
  int rr_exp[4] = '{0, 0, 0, 0};
`else
  int rr_exp[4] = '{0, 1, 0, 1};
`endif

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    aw_v = '0; w_v = '0; w_last = '0; b_ready = '0; ar_v = '0; r_ready = '0;
    m_awready = 0; m_wready = 0; m_bvalid = 0; m_arready = 0; m_rvalid = 0; m_rlast = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    clr();
    cyc(); #2;
    check("rst_awvalid", m_awvalid, 0); check("rst_arvalid", m_arvalid, 0);
    check("rst_aw_ready", aw_ready, 0); check("rst_ar_ready", ar_ready, 0);
    check("rst_w_ready", w_ready, 0); check("rst_wvalid", m_wvalid, 0);
    check("rst_b_v", b_v, 0); check("rst_r_v", r_v, 0);
    check("rst_bready", m_bready, 0); check("rst_rready", m_rready, 0);
    check("rst_aw_sel", aw_sel, 0); check("rst_w_sel", w_sel, 0); check("rst_ar_sel", ar_sel, 0);
    cyc(); rst = 0;
    // Both slots request AW continuously
    for (int i = 0; i < 4; i++) begin
      cyc(); aw_v = '1; m_awready = 1; #2;
      check("rr_aw_sel", aw_sel, rr_exp[i]);
      check("rr_aw_ready", aw_ready, 1 << rr_exp[i]);
    end
    cyc(); clr(); #2;
    check("rr_wq_size", wq_m.size(), 4);
    for (int i = 0; i < 4; i++) begin
      check("rr_log", aw_log[i], rr_exp[i]);
      check("rr_wq", wq_m[i], rr_exp[i]);
    end
    check("rr_w_sel", w_sel, rr_exp[0]);
    for (int i = 0; i < 4; i++) begin
      cyc(); w_v = '1; w_last = '1; m_wready = 1; m_bvalid = 1; b_ready = '1; #2;
      check("rr_drain_w_ready", w_ready, 1 << rr_exp[i]);
      check("rr_drain_b_v", b_v, 1 << rr_exp[i]);
    end
    cyc(); clr();
    // AR HOLD stability
    for (int i = 0; i < 3; i++) begin
      cyc(); ar_v = 2'b10; #2;
      check("hold_ar_sel", ar_sel, 1); check("hold_arvalid", m_arvalid, 1);
    end
    cyc(); ar_v = 2'b11; #2;
    check("hold_ar_sel_both", ar_sel, 1); check("hold_ar_ready", ar_ready, 0);
    cyc(); m_arready = 1; #2;
    check("hold_hs_sel", ar_sel, 1); check("hold_hs_ready", ar_ready, 2'b10);
    cyc(); ar_v = 2'b01; #2;
    check("hold_next_sel", ar_sel, 0); check("hold_next_ready", ar_ready, 2'b01);
    cyc(); clr(); m_rvalid = 1; m_rlast = 1; r_ready = '1; #2;
    check("hold_r_v0", r_v, 2'b10);
    cyc(); #2;
    check("hold_r_v1", r_v, 2'b01);
    cyc(); clr(); r_ready = '1; #2;
    check("hold_rready_empty", m_rready, 0);
    // W ordering: AW slot 1 then slot 0, slot 0 presents W first
    cyc(); aw_v = 2'b10; m_awready = 1; #2;
    check("word_aw1", aw_sel, 1);
    cyc(); aw_v = 2'b01; #2;
    check("word_aw0", aw_sel, 0);
    cyc(); clr(); w_v = 2'b01; w_last = 2'b01; m_wready = 1; #2;
    check("word_block_ready", w_ready, 2'b10); check("word_block_valid", m_wvalid, 0);
    check("word_block_sel", w_sel, 1);
    cyc(); #2;
    check("word_block_ready2", w_ready, 2'b10);
    for (int b = 0; b < 4; b++) begin
      cyc(); w_v = 2'b11; w_last = (b == 3) ? 2'b10 : 2'b00; #2;
      check("word_s1_ready", w_ready, 2'b10); check("word_s1_sel", w_sel, 1);
      check("word_s1_valid", m_wvalid, 1);
    end
    for (int b = 0; b < 4; b++) begin
      cyc(); w_v = 2'b01; w_last = (b == 3) ? 2'b01 : 2'b00; #2;
      check("word_s0_ready", w_ready, 2'b01); check("word_s0_sel", w_sel, 0);
    end
    cyc(); clr(); m_bvalid = 1; b_ready = '1; #2;
    check("word_b0", b_v, 2'b10);
    cyc(); #2;
    check("word_b1", b_v, 2'b01);
    cyc(); clr();
    // Full queue: 8 writes outstanding without B
    for (int i = 0; i < 8; i++) begin
      cyc(); aw_v = 2'b01; m_awready = 1; w_v = 2'b01; w_last = 2'b01; m_wready = 1; #2;
      check("full_fill", aw_ready, 2'b01);
    end
    cyc(); #2;
    check("full_stall", m_awvalid, 0);
    cyc(); m_bvalid = 1; b_ready = 2'b01; #2;
    check("full_pop_same_cycle", m_awvalid, 0); check("full_b_v", b_v, 2'b01);
    cyc(); m_bvalid = 0; #2;
    check("full_reopen_valid", m_awvalid, 1); check("full_reopen_ready", aw_ready, 2'b01);
    for (int i = 0; i < 12; i++) begin
      cyc(); aw_v = '0; m_bvalid = bq_m.size() > 0; b_ready = 2'b01;
    end
    cyc(); clr(); b_ready = '1; #2;
    check("full_bq_empty", bq_m.size(), 0); check("full_wq_empty", wq_m.size(), 0);
    check("full_bready_empty", m_bready, 0);
    // R routing: AR slot 0 then slot 1
    cyc(); clr(); ar_v = 2'b01; m_arready = 1; #2;
    check("r_ar0", ar_sel, 0);
    cyc(); ar_v = 2'b10; #2;
    check("r_ar1", ar_sel, 1);
    cyc(); clr(); m_rvalid = 1; r_ready = '1; m_rlast = 0; #2;
    check("r_beat0", r_v, 2'b01);
    cyc(); m_rlast = 1; #2;
    check("r_beat1", r_v, 2'b01);
    cyc(); #2;
    check("r_beat2", r_v, 2'b10);
    cyc(); clr(); r_ready = '1; #2;
    check("r_rready_empty", m_rready, 0); check("r_rq_empty", rq_m.size(), 0);
    cyc(); clr();
    cyc();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
